// File: rtl/decode_pkg.sv
// Shared MIPS-32 decode definitions: opcode values,
// instruction class encodings, field offsets and the field bundle.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ITYPE_R   = 2'd0;
   localparam logic [1:0] ITYPE_I   = 2'd1;
   localparam logic [1:0] ITYPE_J   = 2'd2;
   localparam logic [1:0] ITYPE_ILL = 2'd3;

   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int SH_LSB  = 6;
   localparam int FN_LSB  = 0;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  func;
      logic [15:0] imm;
      logic [1:0]  itype;
   } fields_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Handshake bus of the decode stage: fetch side in, decoded bundle out.
// master = fetch/consumer environment, slave = the decode stage.
interface instr_decode_stage_if #(
   parameter int PC_W      = 32,
   parameter int IMM_EXT_W = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_code;
   logic [PC_W-1:0]      in_pc;
   logic                 out_valid;
   logic                 out_ready;
   logic [5:0]           opcode;
   logic [4:0]           rs;
   logic [4:0]           rt;
   logic [4:0]           rd;
   logic [4:0]           shamt;
   logic [5:0]           func;
   logic [15:0]          imm;
   logic [IMM_EXT_W-1:0] imm_ext;
   logic [PC_W-1:0]      jtarget;
   logic [1:0]           itype;
   logic [PC_W-1:0]      out_pc;

   modport master (
      output in_valid, in_code, in_pc, out_ready,
      input  in_ready, out_valid, opcode, rs, rt, rd,
      input  shamt, func, imm, imm_ext, jtarget, itype, out_pc
   );

   modport slave (
      input  in_valid, in_code, in_pc, out_ready,
      output in_ready, out_valid, opcode, rs, rt, rd,
      output shamt, func, imm, imm_ext, jtarget, itype, out_pc
   );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational MIPS-32 word decode: fields, class, extended imm, jump target.
// Ports: code/pc in; f (fields + class), imm_ext, jtarget out.
module instr_field_decode
   import decode_pkg::*;
#(
   parameter int IMM_EXT_W  = 32,
   parameter int PC_W       = 32,
   parameter bit LOGIC_ZEXT = 1'b1
) (
   input  logic [31:0]          code,
   input  logic [PC_W-1:0]      pc,
   output fields_t              f,
   output logic [IMM_EXT_W-1:0] imm_ext,
   output logic [PC_W-1:0]      jtarget
);

   logic [5:0]      op;
   logic [15:0]     imm;
   logic [31:0]     lui32;
   logic [PC_W-1:0] pc4;
   logic            is_j;
   logic            is_i;
   logic            is_log;

   assign op     = code[OPC_LSB +: 6];
   assign imm    = code[IMM_LSB +: 16];
   assign lui32  = {imm, 16'h0000};
   assign is_j   = (op == OP_J) || (op == OP_JAL);
   assign is_i   = (op == OP_BEQ) || (op == OP_BNE) ||
                   (op >= OP_ADDI && op <= OP_LUI) ||
                   (op == OP_LW) || (op == OP_SW);
   assign is_log = (op >= OP_ANDI) && (op <= OP_XORI);

   always_comb begin
      f        = '0;
      f.opcode = op;
      f.rs     = code[RS_LSB +: 5];
      f.rt     = code[RT_LSB +: 5];
      f.rd     = code[RD_LSB +: 5];
      f.shamt  = code[SH_LSB +: 5];
      f.func   = code[FN_LSB +: 6];
      f.imm    = imm;
      unique case (1'b1)
         (op == OP_RTYPE): f.itype = ITYPE_R;
         is_j:             f.itype = ITYPE_J;
         is_i:             f.itype = ITYPE_I;
         default:          f.itype = ITYPE_ILL;
      endcase
   end

   always_comb begin
      imm_ext = '0;
      unique case (1'b1)
         (op == OP_LUI):       imm_ext = IMM_EXT_W'(lui32);
         (LOGIC_ZEXT && is_log): imm_ext = IMM_EXT_W'(imm);
         default:              imm_ext = IMM_EXT_W'($signed(imm));
      endcase
   end

   // Upper PC bits come from pc+4 (wraps silently); low 28 from the word.
   assign pc4     = pc + PC_W'(4);
   assign jtarget = (pc4 & ~PC_W'(32'h0FFF_FFFF)) |
                    PC_W'({code[25:0], 2'b00});

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with output register plus 1-entry skid buffer.
// Ports: clk, rst_n (sync, active low), flush, bus (slave handshake bus).
module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int IMM_EXT_W  = 32,
   parameter int PC_W       = 32,
   parameter bit LOGIC_ZEXT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   instr_decode_stage_if.slave  bus
);

   typedef struct packed {
      fields_t              f;
      logic [IMM_EXT_W-1:0] imm_ext;
      logic [PC_W-1:0]      jtarget;
      logic [PC_W-1:0]      pc;
   } bundle_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t  state;
   bundle_t dec;
   bundle_t or_q;
   bundle_t sk_q;
   logic    out_valid_q;
   logic    in_ready_q;
   logic    acc;
   logic    drn;

   instr_field_decode #(
      .IMM_EXT_W (IMM_EXT_W),
      .PC_W      (PC_W),
      .LOGIC_ZEXT(LOGIC_ZEXT)
   ) u_dec (
      .code   (bus.in_code),
      .pc     (bus.in_pc),
      .f      (dec.f),
      .imm_ext(dec.imm_ext),
      .jtarget(dec.jtarget)
   );

   assign dec.pc = bus.in_pc;
   assign acc    = bus.in_valid && in_ready_q;
   assign drn    = out_valid_q && bus.out_ready;

   // OR only changes when empty or draining, so a stalled
   // bundle holds steady.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= EMPTY;
         or_q        <= '0;
         sk_q        <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (acc) begin
                  or_q        <= dec;
                  out_valid_q <= 1'b1;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (acc && drn) begin
                  or_q <= dec;
               end else if (drn) begin
                  out_valid_q <= 1'b0;
                  state       <= EMPTY;
               end else if (acc) begin
                  sk_q       <= dec;
                  in_ready_q <= 1'b0;
                  state      <= TWO;
               end
            end
            TWO: begin
               if (drn) begin
                  or_q       <= sk_q;
                  in_ready_q <= 1'b1;
                  state      <= ONE;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.opcode    = or_q.f.opcode;
   assign bus.rs        = or_q.f.rs;
   assign bus.rt        = or_q.f.rt;
   assign bus.rd        = or_q.f.rd;
   assign bus.shamt     = or_q.f.shamt;
   assign bus.func      = or_q.f.func;
   assign bus.imm       = or_q.f.imm;
   assign bus.itype     = or_q.f.itype;
   assign bus.imm_ext   = or_q.imm_ext;
   assign bus.jtarget   = or_q.jtarget;
   assign bus.out_pc    = or_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed cases plus random traffic
// against a queue-based reference; two instances (LOGIC_ZEXT 1 and 0).
module tb_instr_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_code;
   logic [31:0] in_pc;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] code;
      logic [31:0] pc;
   } beat_t;

   beat_t q[$];

   instr_decode_stage_if #(.PC_W(32), .IMM_EXT_W(32)) if0 ();
   instr_decode_stage_if #(.PC_W(32), .IMM_EXT_W(32)) if1 ();

   assign if0.in_valid  = in_valid;
   assign if0.in_code   = in_code;
   assign if0.in_pc     = in_pc;
   assign if0.out_ready = out_ready;
   assign if1.in_valid  = in_valid;
   assign if1.in_code   = in_code;
   assign if1.in_pc     = in_pc;
   assign if1.out_ready = out_ready;

   instr_decode_stage #(
      .IMM_EXT_W(32), .PC_W(32), .LOGIC_ZEXT(1'b1)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0)
   );

   instr_decode_stage #(
      .IMM_EXT_W(32), .PC_W(32), .LOGIC_ZEXT(1'b0)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_itype(input logic [5:0] op);
      if (op == 6'd0) return 2'd0;
      if (op == 6'd2 || op == 6'd3) return 2'd2;
      if (op == 6'd4 || op == 6'd5 || (op >= 6'd8 && op <= 6'd15) ||
          op == 6'h23 || op == 6'h2B) return 2'd1;
      return 2'd3;
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] c,
                                         input bit zx);
      int v;
      int op;
      v  = int'(c[15:0]);
      op = int'(c[31:26]);
      if (op == 15) return 32'(v * 65536);
      if (zx && op >= 12 && op <= 14) return 32'(v);
      if (v >= 32768) return 32'(v - 65536);
      return 32'(v);
   endfunction

   function automatic logic [31:0] m_jt(input logic [31:0] c,
                                        input logic [31:0] pc);
      logic [31:0] t;
      t = c & 32'h03FF_FFFF;
      return ((pc + 32'd4) & 32'hF000_0000) | (t * 4);
   endfunction

   task automatic check_all();
      beat_t b;
      chk("in_ready", 64'(if0.in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(if0.out_valid), 64'(q.size() > 0));
      chk("u1_in_ready", 64'(if1.in_ready), 64'(q.size() < 2));
      chk("u1_out_valid", 64'(if1.out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         b = q[0];
         chk("fields", 64'({if0.opcode, if0.rs, if0.rt, if0.rd,
                            if0.shamt, if0.func}), 64'(b.code));
         chk("imm", 64'(if0.imm), 64'(b.code[15:0]));
         chk("imm_ext", 64'(if0.imm_ext), 64'(m_imm(b.code, 1'b1)));
         chk("u1_imm_ext", 64'(if1.imm_ext), 64'(m_imm(b.code, 1'b0)));
         chk("jtarget", 64'(if0.jtarget), 64'(m_jt(b.code, b.pc)));
         chk("itype", 64'(if0.itype), 64'(m_itype(b.code[31:26])));
         chk("out_pc", 64'(if0.out_pc), 64'(b.pc));
      end
   endtask

   // One clock: drive, update reference at the edge, check at negedge.
   task automatic cyc(input bit v, input logic [31:0] c,
                      input logic [31:0] p, input bit rdy,
                      input bit fl);
      bit drn;
      bit acc;
      in_valid  = v;
      in_code   = c;
      in_pc     = p;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      drn = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back('{in_code, in_pc});
      end
      @(negedge clk);
      check_all();
   endtask

   logic [5:0] pool [8];

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_code   = '0;
      in_pc     = '0;
      pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h3F};

      cyc(1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("rst_fields", 64'({if0.opcode, if0.rs, if0.rt, if0.rd,
                             if0.shamt, if0.func, if0.imm}), 64'd0);
      chk("rst_ext", 64'({if0.imm_ext, if0.jtarget}), 64'd0);
      chk("rst_pc_itype", 64'({if0.out_pc, if0.itype}), 64'd0);
      rst_n = 1'b1;

      // ori, 1-cycle latency
      cyc(1'b1, 32'h3410_0001, 32'h0, 1'b0, 1'b0);
      chk("t1_valid", 64'(if0.out_valid), 64'd1);
      chk("t1_opcode", 64'(if0.opcode), 64'h0D);
      chk("t1_rs_rt", 64'({if0.rs, if0.rt}), 64'({5'd0, 5'd16}));
      chk("t1_imm", 64'(if0.imm), 64'd1);
      chk("t1_imm_ext", 64'(if0.imm_ext), 64'h0000_0001);
      chk("t1_itype", 64'(if0.itype), 64'd1);

      cyc(1'b1, 32'h3C01_ABCD, 32'h4, 1'b1, 1'b0);
      chk("t2_lui", 64'(if0.imm_ext), 64'hABCD_0000);
      cyc(1'b1, 32'h2002_FFFF, 32'h8, 1'b1, 1'b0);
      chk("t2_addi", 64'(if0.imm_ext), 64'hFFFF_FFFF);
      cyc(1'b1, 32'h3402_FFFF, 32'hC, 1'b1, 1'b0);
      chk("t2_ori_sext", 64'(if1.imm_ext), 64'hFFFF_FFFF);
      chk("t2_ori_zext", 64'(if0.imm_ext), 64'h0000_FFFF);

      cyc(1'b1, 32'h0800_0010, 32'hF000_0000, 1'b1, 1'b0);
      chk("t3_j_itype", 64'(if0.itype), 64'd2);
      chk("t3_jtarget", 64'(if0.jtarget), 64'hF000_0040);
      cyc(1'b1, 32'hFC00_1234, 32'h10, 1'b1, 1'b0);
      chk("t3_ill_itype", 64'(if0.itype), 64'd3);
      chk("t3_ill_valid", 64'(if0.out_valid), 64'd1);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // backpressure into skid
      cyc(1'b1, 32'h2001_0001, 32'h100, 1'b0, 1'b0);
      cyc(1'b1, 32'h2001_0002, 32'h104, 1'b0, 1'b0);
      chk("t4_ready_low", 64'(if0.in_ready), 64'd0);
      cyc(1'b1, 32'h2001_0003, 32'h108, 1'b0, 1'b0);
      chk("t4_hold", 64'(if0.imm), 64'd1);
      cyc(1'b1, 32'h2001_0003, 32'h108, 1'b1, 1'b0);
      chk("t4_second", 64'(if0.imm), 64'd2);
      cyc(1'b1, 32'h2001_0003, 32'h108, 1'b1, 1'b0);
      chk("t4_third", 64'(if0.imm), 64'd3);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // flush in TWO with incoming beat
      cyc(1'b1, 32'h2001_0011, 32'h200, 1'b0, 1'b0);
      cyc(1'b1, 32'h2001_0012, 32'h204, 1'b0, 1'b0);
      cyc(1'b1, 32'h2001_0013, 32'h208, 1'b0, 1'b1);
      chk("t5_valid", 64'(if0.out_valid), 64'd0);
      chk("t5_ready", 64'(if0.in_ready), 64'd1);
      cyc(1'b1, 32'h2001_0014, 32'h20C, 1'b0, 1'b0);
      chk("t5_next", 64'(if0.imm), 64'h14);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // reset mid-stream under backpressure
      cyc(1'b1, 32'h2001_0021, 32'h300, 1'b0, 1'b0);
      rst_n = 1'b0;
      cyc(1'b1, 32'h2001_0022, 32'h304, 1'b0, 1'b0);
      chk("t6_valid", 64'(if0.out_valid), 64'd0);
      chk("t6_ready", 64'(if0.in_ready), 64'd1);
      rst_n = 1'b1;

      for (int n = 0; n < 10000; n++) begin
         logic [31:0] c;
         logic [31:0] p;
         c = $urandom;
         if ($urandom_range(0, 1) == 1)
            c[31:26] = pool[$urandom_range(0, 7)];
         p = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFFC;
         rst_n = ($urandom_range(0, 499) != 0);
         cyc($urandom_range(0, 3) != 0, c, p,
             $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      end
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
